// File: rtl/mc_controller_pkg.sv
// ============================================================================
// Module      : mc_controller_pkg
// Description : Shared opcode/funct codes, ALU-op and immediate codes and
//               FSM state encodings for the multicycle MIPS controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_controller_pkg;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_ADD = 6'h20;
    localparam logic [5:0] c_FN_SUB = 6'h22;
    localparam logic [5:0] c_FN_AND = 6'h24;
    localparam logic [5:0] c_FN_OR  = 6'h25;
    localparam logic [5:0] c_FN_SLT = 6'h2A;

    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] c_ALUOP_OR    = 2'b11;

    localparam logic [1:0] c_IMM_SIGN  = 2'b00;
    localparam logic [1:0] c_IMM_ZERO  = 2'b01;
    localparam logic [1:0] c_IMM_UPPER = 2'b10;

    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    localparam logic [3:0] c_S_FETCH  = 4'd0;
    localparam logic [3:0] c_S_DECODE = 4'd1;
    localparam logic [3:0] c_S_MEMADR = 4'd2;
    localparam logic [3:0] c_S_MEMRD  = 4'd3;
    localparam logic [3:0] c_S_MEMWB  = 4'd4;
    localparam logic [3:0] c_S_MEMWR  = 4'd5;
    localparam logic [3:0] c_S_EXEC   = 4'd6;
    localparam logic [3:0] c_S_ALUWB  = 4'd7;
    localparam logic [3:0] c_S_BRANCH = 4'd8;
    localparam logic [3:0] c_S_IMMEX  = 4'd9;
    localparam logic [3:0] c_S_IMMWB  = 4'd10;
    localparam logic [3:0] c_S_JUMP   = 4'd11;
    localparam logic [3:0] c_S_TRAP   = 4'd12;

    function automatic logic is_known_op(input logic [5:0] op);
        case (op)
            c_OP_RTYPE, c_OP_J, c_OP_BEQ, c_OP_ADDI,
            c_OP_ORI, c_OP_LUI, c_OP_LW, c_OP_SW: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_controller_aludec.sv
// ============================================================================
// Module      : mc_controller_aludec
// Description : Maps the controller ALU-op and the R-type funct field to the
//               3-bit ALU control code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_controller_aludec (
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);
    import mc_controller_pkg::*;

    always_comb begin
        alucontrol = c_ALU_ADD;
        case (aluop)
            c_ALUOP_ADD: alucontrol = c_ALU_ADD;
            c_ALUOP_SUB: alucontrol = c_ALU_SUB;
            c_ALUOP_OR:  alucontrol = c_ALU_OR;
            default: begin
                case (funct)
                    c_FN_ADD: alucontrol = c_ALU_ADD;
                    c_FN_SUB: alucontrol = c_ALU_SUB;
                    c_FN_AND: alucontrol = c_ALU_AND;
                    c_FN_OR:  alucontrol = c_ALU_OR;
                    c_FN_SLT: alucontrol = c_ALU_SLT;
                    // Unsupported funct is not trapped; leave it undefined
                    default:  alucontrol = 3'bxxx;
                endcase
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
// ============================================================================
// Module      : mc_controller
// Description : Multicycle MIPS control FSM with a mem_ready wait handshake
//               on every memory access; outputs decoded from the state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_controller #(
    parameter int ILLEGAL_TRAP = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] immtype,
    output logic [2:0] alucontrol,
    output logic       instr_done,
    output logic       illegal_op
);
    import mc_controller_pkg::*;

    localparam logic c_TRAP_EN = (ILLEGAL_TRAP != 0);

    logic [3:0] r_state;
    logic       w_pcwrite;
    logic       w_branch;
    logic [1:0] w_aluop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_FETCH;
        end else begin
            case (r_state)
                c_S_FETCH:  r_state <= mem_ready ? c_S_DECODE : c_S_FETCH;
                c_S_DECODE: begin
                    case (op)
                        c_OP_LW, c_OP_SW:              r_state <= c_S_MEMADR;
                        c_OP_RTYPE:                    r_state <= c_S_EXEC;
                        c_OP_BEQ:                      r_state <= c_S_BRANCH;
                        c_OP_ADDI, c_OP_ORI, c_OP_LUI: r_state <= c_S_IMMEX;
                        c_OP_J:                        r_state <= c_S_JUMP;
                        default: r_state <= c_TRAP_EN ? c_S_TRAP : c_S_FETCH;
                    endcase
                end
                c_S_MEMADR: r_state <= (op == c_OP_LW) ? c_S_MEMRD : c_S_MEMWR;
                c_S_MEMRD:  r_state <= mem_ready ? c_S_MEMWB : c_S_MEMRD;
                c_S_MEMWB:  r_state <= c_S_FETCH;
                c_S_MEMWR:  r_state <= mem_ready ? c_S_FETCH : c_S_MEMWR;
                c_S_EXEC:   r_state <= c_S_ALUWB;
                c_S_ALUWB:  r_state <= c_S_FETCH;
                c_S_BRANCH: r_state <= c_S_FETCH;
                c_S_IMMEX:  r_state <= c_S_IMMWB;
                c_S_IMMWB:  r_state <= c_S_FETCH;
                c_S_JUMP:   r_state <= c_S_FETCH;
                c_S_TRAP:   r_state <= c_S_TRAP;
                default:    r_state <= c_S_FETCH;
            endcase
        end
    end

    always_comb begin
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_aluop    = c_ALUOP_ADD;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        immtype    = c_IMM_SIGN;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (r_state)
            c_S_FETCH: begin
                alusrcb   = 2'b01;
                irwrite   = mem_ready;
                w_pcwrite = mem_ready;
            end
            c_S_DECODE: begin
                alusrcb = 2'b11;
                if (!is_known_op(op)) begin
                    illegal_op = 1'b1;
                    instr_done = !c_TRAP_EN;
                end
            end
            c_S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            c_S_MEMRD: iord = 1'b1;
            c_S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            c_S_MEMWR: begin
                iord       = 1'b1;
                memwrite   = 1'b1;
                instr_done = mem_ready;
            end
            c_S_EXEC: begin
                alusrca = 1'b1;
                w_aluop = c_ALUOP_FUNCT;
            end
            c_S_ALUWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            c_S_BRANCH: begin
                alusrca    = 1'b1;
                w_aluop    = c_ALUOP_SUB;
                pcsrc      = 2'b01;
                w_branch   = 1'b1;
                instr_done = 1'b1;
            end
            c_S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (op == c_OP_ORI) begin
                    w_aluop = c_ALUOP_OR;
                    immtype = c_IMM_ZERO;
                end else if (op == c_OP_LUI) begin
                    w_aluop = c_ALUOP_OR;
                    immtype = c_IMM_UPPER;
                end
            end
            c_S_IMMWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            c_S_JUMP: begin
                pcsrc      = 2'b10;
                w_pcwrite  = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase

        // Reset cycle: present FETCH values with every strobe suppressed
        if (reset) begin
            w_pcwrite  = 1'b0;
            w_branch   = 1'b0;
            w_aluop    = c_ALUOP_ADD;
            iord       = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            regwrite   = 1'b0;
            regdst     = 1'b0;
            memtoreg   = 1'b0;
            alusrca    = 1'b0;
            alusrcb    = 2'b01;
            pcsrc      = 2'b00;
            immtype    = c_IMM_SIGN;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign pcen = w_pcwrite | (w_branch & zero);

    mc_controller_aludec u_aludec (
        .aluop      (w_aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// ============================================================================
// Module      : tb_mc_controller
// Description : Randomized scoreboard bench for mc_controller (trap and
//               non-trap builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, zero, mem_ready;
    logic [5:0] op, funct;
    logic       pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc, immtype;
    logic [2:0] alucontrol;
    logic       instr_done, illegal_op;

    logic       reset_t, zero_t, mem_ready_t;
    logic [5:0] op_t, funct_t;
    logic       pcen_t, iord_t, memwrite_t, irwrite_t, regwrite_t, regdst_t, memtoreg_t, alusrca_t;
    logic [1:0] alusrcb_t, pcsrc_t, immtype_t;
    logic [2:0] alucontrol_t;
    logic       instr_done_t, illegal_op_t;

    mc_controller #(.ILLEGAL_TRAP(0)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .immtype(immtype), .alucontrol(alucontrol),
        .instr_done(instr_done), .illegal_op(illegal_op)
    );

    mc_controller #(.ILLEGAL_TRAP(1)) dut_t (
        .clk(clk), .reset(reset_t), .op(op_t), .funct(funct_t), .zero(zero_t), .mem_ready(mem_ready_t),
        .pcen(pcen_t), .iord(iord_t), .memwrite(memwrite_t), .irwrite(irwrite_t), .regwrite(regwrite_t),
        .regdst(regdst_t), .memtoreg(memtoreg_t), .alusrca(alusrca_t), .alusrcb(alusrcb_t),
        .pcsrc(pcsrc_t), .immtype(immtype_t), .alucontrol(alucontrol_t),
        .instr_done(instr_done_t), .illegal_op(illegal_op_t)
    );

    logic [13:0] w_vec, w_vec_t;
    assign w_vec   = {pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
                      alusrca, alusrcb, pcsrc, instr_done, illegal_op};
    assign w_vec_t = {pcen_t, iord_t, memwrite_t, irwrite_t, regwrite_t, regdst_t, memtoreg_t,
                      alusrca_t, alusrcb_t, pcsrc_t, instr_done_t, illegal_op_t};

    typedef struct {
        logic [5:0] op;
        int         cycles, pcen_n, irw_n, rw_n, mw_n, iord_n, ill_n;
        logic       wb_regdst, wb_memtoreg, has_ex, ex_a;
        logic [1:0] dec_b, ex_b, ex_pcsrc, ex_imm;
        logic [2:0] ex_alu;
    } rec_t;

    typedef struct {
        string       name;
        logic        trap;
        logic [13:0] val;
        logic        sqchk;
    } dexp_t;

    rec_t  sq[$];
    dexp_t dq[$];
    int    checks = 0;
    int    errors = 0;
    logic  rnd_en = 1'b0;

    // Instruction-level behaviour, expressed as per-instruction totals
    function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
        case (f)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    function automatic rec_t model(input logic [5:0] o, input logic [5:0] f,
                                   input logic z, input int fs, input int ms);
        rec_t r;
        r.op = o; r.cycles = fs + 4; r.pcen_n = 1; r.irw_n = 1; r.rw_n = 0; r.mw_n = 0;
        r.iord_n = 0; r.ill_n = 0; r.wb_regdst = 0; r.wb_memtoreg = 0; r.has_ex = 1;
        r.dec_b = 2'b11; r.ex_a = 1; r.ex_b = 2'b00; r.ex_pcsrc = 2'b00; r.ex_imm = 2'b00;
        r.ex_alu = 3'b010;
        case (o)
            6'h00: begin r.rw_n = 1; r.wb_regdst = 1; r.ex_alu = alu_of_funct(f); end
            6'h23: begin r.cycles = fs + 5 + ms; r.rw_n = 1; r.wb_memtoreg = 1;
                         r.iord_n = ms + 1; r.ex_b = 2'b10; end
            6'h2B: begin r.cycles = fs + 4 + ms; r.mw_n = ms + 1; r.iord_n = ms + 1;
                         r.ex_b = 2'b10; end
            6'h04: begin r.cycles = fs + 3; r.pcen_n = z ? 2 : 1; r.ex_pcsrc = 2'b01;
                         r.ex_alu = 3'b110; end
            6'h08: begin r.rw_n = 1; r.ex_b = 2'b10; end
            6'h0D: begin r.rw_n = 1; r.ex_b = 2'b10; r.ex_imm = 2'b01; r.ex_alu = 3'b001; end
            6'h0F: begin r.rw_n = 1; r.ex_b = 2'b10; r.ex_imm = 2'b10; r.ex_alu = 3'b001; end
            6'h02: begin r.cycles = fs + 3; r.pcen_n = 2; r.ex_a = 0; r.ex_pcsrc = 2'b10; end
            default: begin r.cycles = fs + 2; r.ill_n = 1; r.has_ex = 0; end
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: directed per-cycle expectations first, else instruction scoreboard
    rec_t  obs, e;
    dexp_t d;
    int    cyc = 0;
    int    ir_idx = -1;

    task automatic clear_obs();
        cyc = 0; ir_idx = -1;
        obs.pcen_n = 0; obs.irw_n = 0; obs.rw_n = 0; obs.mw_n = 0; obs.iord_n = 0; obs.ill_n = 0;
        obs.wb_regdst = 0; obs.wb_memtoreg = 0; obs.dec_b = 2'b00; obs.ex_a = 0;
        obs.ex_b = 2'b00; obs.ex_pcsrc = 2'b00; obs.ex_imm = 2'b00; obs.ex_alu = 3'b000;
    endtask

    initial clear_obs();

    always @(negedge clk) begin
        if (dq.size() > 0) begin
            d = dq.pop_front();
            if (d.sqchk) chk("scoreboard_drained", sq.size(), 0);
            chk(d.name, d.trap ? int'(w_vec_t) : int'(w_vec), int'(d.val));
        end else if (rnd_en) begin
            if (irwrite && ir_idx < 0) ir_idx = cyc;
            obs.pcen_n += int'(pcen);
            obs.irw_n  += int'(irwrite);
            obs.rw_n   += int'(regwrite);
            obs.mw_n   += int'(memwrite);
            obs.iord_n += int'(iord);
            obs.ill_n  += int'(illegal_op);
            if (regwrite) begin
                obs.wb_regdst   |= regdst;
                obs.wb_memtoreg |= memtoreg;
            end
            if (ir_idx >= 0 && cyc == ir_idx + 1) obs.dec_b = alusrcb;
            if (ir_idx >= 0 && cyc == ir_idx + 2) begin
                obs.ex_a = alusrca; obs.ex_b = alusrcb; obs.ex_pcsrc = pcsrc;
                obs.ex_imm = immtype; obs.ex_alu = alucontrol;
            end
            cyc++;
            if (instr_done) begin
                if (sq.size() == 0) begin
                    chk("unexpected_instr_done", 1, 0);
                end else begin
                    e = sq.pop_front();
                    chk($sformatf("op%02h_cycles", e.op), cyc, e.cycles);
                    chk($sformatf("op%02h_pcen_count", e.op), obs.pcen_n, e.pcen_n);
                    chk($sformatf("op%02h_irwrite_count", e.op), obs.irw_n, e.irw_n);
                    chk($sformatf("op%02h_regwrite_count", e.op), obs.rw_n, e.rw_n);
                    chk($sformatf("op%02h_memwrite_count", e.op), obs.mw_n, e.mw_n);
                    chk($sformatf("op%02h_iord_count", e.op), obs.iord_n, e.iord_n);
                    chk($sformatf("op%02h_illegal_count", e.op), obs.ill_n, e.ill_n);
                    chk($sformatf("op%02h_decode_alusrcb", e.op), obs.dec_b, e.dec_b);
                    if (e.rw_n > 0) begin
                        chk($sformatf("op%02h_wb_regdst", e.op), obs.wb_regdst, e.wb_regdst);
                        chk($sformatf("op%02h_wb_memtoreg", e.op), obs.wb_memtoreg, e.wb_memtoreg);
                    end
                    if (e.has_ex) begin
                        chk($sformatf("op%02h_ex_alusrca", e.op), obs.ex_a, e.ex_a);
                        chk($sformatf("op%02h_ex_alusrcb", e.op), obs.ex_b, e.ex_b);
                        chk($sformatf("op%02h_ex_pcsrc", e.op), obs.ex_pcsrc, e.ex_pcsrc);
                        chk($sformatf("op%02h_ex_immtype", e.op), obs.ex_imm, e.ex_imm);
                        chk($sformatf("op%02h_ex_alucontrol", e.op), obs.ex_alu, e.ex_alu);
                    end
                end
                clear_obs();
            end else if (cyc > 40) begin
                chk("instr_done_timeout", cyc, 0);
                if (sq.size() > 0) void'(sq.pop_front());
                clear_obs();
            end
        end
    end

    task automatic push_d(input string nm, input logic tr, input logic [13:0] v, input logic sc);
        dexp_t x;
        x.name = nm; x.trap = tr; x.val = v; x.sqchk = sc;
        dq.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] ops[12] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h04, 6'h08, 6'h0D, 6'h0F,
                            6'h02, 6'h3F, 6'h01, 6'h3A};
    logic [5:0] fns[5]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    initial begin
        rec_t       r;
        logic [5:0] o, f;
        logic       z, memop;
        int         fs, ms;

        reset = 1; op = 0; funct = 6'h20; zero = 0; mem_ready = 1;
        reset_t = 1; op_t = 6'h3F; funct_t = 0; zero_t = 0; mem_ready_t = 1;
        step();
        repeat (2) begin
            push_d("reset_outputs", 0, 14'h0010, 0);
            step();
        end
        reset = 0;
        rnd_en = 1;

        for (int i = 0; i < 70; i++) begin
            o  = (i < 12) ? ops[i] : ops[$urandom_range(0, 11)];
            f  = (o == 6'h00) ? fns[$urandom_range(0, 4)] : 6'($urandom);
            z  = (i == 3) ? 1'b1 : (i == 4) ? 1'b0 : 1'($urandom);
            fs = (i < 12) ? 0 : $urandom_range(0, 2);
            ms = (i == 1) ? 2 : (i < 12) ? 0 : $urandom_range(0, 3);
            memop = (o == 6'h23) || (o == 6'h2B);
            r = model(o, f, z, fs, ms);
            sq.push_back(r);
            for (int c = 0; c < r.cycles; c++) begin
                op = o;
                funct = f;
                zero = (o == 6'h04) ? z : 1'($urandom);
                if (c < fs)                          mem_ready = 1'b0;
                else if (c == fs)                    mem_ready = 1'b1;
                else if (memop && c >= fs + 3 && c < fs + 3 + ms) mem_ready = 1'b0;
                else if (memop && c == fs + 3 + ms)  mem_ready = 1'b1;
                else                                 mem_ready = 1'($urandom);
                step();
            end
        end
        rnd_en = 0;

        // Store abandoned by reset while waiting in the write state
        op = 6'h2B; funct = 0; zero = 0; mem_ready = 1;
        push_d("sw_fetch", 0, 14'h2410, 1); step();
        push_d("sw_decode", 0, 14'h0030, 0); step();
        push_d("sw_memadr", 0, 14'h0060, 0); step();
        mem_ready = 0;
        push_d("sw_memwr_wait", 0, 14'h1800, 0); step();
        reset = 1;
        push_d("sw_reset_cycle", 0, 14'h0010, 0); step();
        reset = 0;
        push_d("sw_after_reset_fetch_wait", 0, 14'h0010, 0); step();
        mem_ready = 1;
        push_d("sw_after_reset_fetch", 0, 14'h2410, 0); step();

        // Trapping build parks on an unknown opcode
        reset_t = 0; op_t = 6'h3F; mem_ready_t = 1;
        push_d("trap_fetch", 1, 14'h2410, 0); step();
        push_d("trap_decode", 1, 14'h0031, 0); step();
        for (int k = 0; k < 10; k++) begin
            mem_ready_t = 1'($urandom);
            zero_t = 1'($urandom);
            push_d($sformatf("trap_hold_%0d", k), 1, 14'h0000, 0);
            step();
        end
        reset_t = 1;
        push_d("trap_reset", 1, 14'h0010, 0); step();
        reset_t = 0; mem_ready_t = 1; op_t = 6'h00;
        push_d("trap_exit_fetch", 1, 14'h2410, 0); step();

        @(negedge clk);
        #1;
        for (int k = 0; k < 10 && dq.size() > 0; k++) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
